// File: rtl/sysu_sram_sync_if.sv
// ----------------------------------------------------------------------------
// sysu_sram_sync_if
//   Request/response bundle for the sysu_sram_sync scratch RAM.
//
//   Signals (direction as seen from the RAM, i.e. the slave modport):
//     en        in   chip enable, active-low
//     wr        in   write request
//     rd        in   read request
//     addr      in   word address [ADDR_W]
//     din       in   write data [DATA_W]
//     perr_inj  in   parity flip on write (only meaningful with parity storage)
//     dout      out  read data register, high-Z while en=1 [DATA_W]
//     dvalid    out  one-cycle read data strobe
//     busy      out  initialisation sequence in progress
//     addr_err  out  one-cycle out-of-range request strobe
//     perr      out  one-cycle parity mismatch strobe
// ----------------------------------------------------------------------------
interface sysu_sram_sync_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
);
    logic              en;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              perr_inj;
    wire  [DATA_W-1:0] dout;
    logic              dvalid;
    logic              busy;
    logic              addr_err;
    logic              perr;

    modport master (
        output en, wr, rd, addr, din, perr_inj,
        input  dout, dvalid, busy, addr_err, perr
    );

    modport slave (
        input  en, wr, rd, addr, din, perr_inj,
        output dout, dvalid, busy, addr_err, perr
    );
endinterface

// File: rtl/sysu_sram_sync.sv
// ----------------------------------------------------------------------------
// sysu_sram_sync
//   Synchronous single-address scratch RAM, DATA_W x DEPTH.
//   After reset an init sequencer writes INIT_VAL into every word (busy=1),
//   then requests are accepted whenever the active-low chip enable is low.
//   Reads are registered (1-clock latency, dvalid strobe); a write and read
//   on the same edge return the write data (write-first). Requests to
//   addr >= DEPTH are flagged with addr_err and never touch memory.
//
//   Ports:
//     clk   in  clock, rising edge
//     rst   in  synchronous reset, active-high
//     bus   sysu_sram_sync_if.slave  (see interface header)
//
//   Build option:
//     SYSU_SRAM_PARITY_EN  adds one even-parity bit per word; perr flags a
//                          mismatch on in-range reads. Without it perr is 0
//                          and perr_inj is ignored.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   INIT  | clearing word cnt with INIT_VAL; requests dropped, busy=1
//   IDLE  | normal operation, requests accepted when en=0
// ----------------------------------------------------------------------------
module sysu_sram_sync #(
    parameter int              DATA_W   = 4,
    parameter int              ADDR_W   = 2,
    parameter int              DEPTH    = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic               clk,
    input logic               rst,
    sysu_sram_sync_if.slave   bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata;
    logic              dvalid_q;
    logic              addr_err_q;
    logic              busy_q;
    logic              perr_q;

    logic              in_range;
    logic [IDX_W-1:0]  idx;

    // Compare in ADDR_W+1 bits so DEPTH == 2**ADDR_W does not overflow.
    assign in_range = ({1'b0, bus.addr} < DEPTH_L);
    assign idx      = bus.addr[IDX_W-1:0];

`ifdef SYSU_SRAM_PARITY_EN
    logic mem_par [DEPTH];
`else
    logic unused_perr_inj;
    assign unused_perr_inj = bus.perr_inj;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            cnt        <= '0;
            rdata      <= '0;
            dvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            perr_q     <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            dvalid_q   <= 1'b0;
            addr_err_q <= 1'b0;
            perr_q     <= 1'b0;
            case (state)
                ST_INIT: begin
                    mem[cnt] <= INIT_VAL;
`ifdef SYSU_SRAM_PARITY_EN
                    mem_par[cnt] <= ^INIT_VAL;
`endif
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (!bus.en) begin
                        if (bus.wr && in_range) begin
                            mem[idx] <= bus.din;
`ifdef SYSU_SRAM_PARITY_EN
                            mem_par[idx] <= (^bus.din) ^ bus.perr_inj;
`endif
                        end
                        if (bus.rd) begin
                            dvalid_q <= 1'b1;
                            if (!in_range) begin
                                rdata <= '0;
                            end else if (bus.wr) begin
                                // write-first: return the data being written
                                rdata <= bus.din;
`ifdef SYSU_SRAM_PARITY_EN
                                perr_q <= bus.perr_inj;
`endif
                            end else begin
                                rdata <= mem[idx];
`ifdef SYSU_SRAM_PARITY_EN
                                perr_q <= mem_par[idx] ^ (^mem[idx]);
`endif
                            end
                        end
                        if ((bus.wr || bus.rd) && !in_range) begin
                            addr_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_INIT;
                    cnt    <= '0;
                    busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.dout     = bus.en ? {DATA_W{1'bz}} : rdata;
    assign bus.dvalid   = dvalid_q;
    assign bus.addr_err = addr_err_q;
    assign bus.busy     = busy_q;
    assign bus.perr     = perr_q;

endmodule

// File: tb/tb_sysu_sram_sync.sv
module tb_sysu_sram_sync;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sysu_sram_sync_if #(.DATA_W(4), .ADDR_W(2)) if_a ();
    sysu_sram_sync_if #(.DATA_W(4), .ADDR_W(2)) if_b ();

    sysu_sram_sync #(.DATA_W(4), .ADDR_W(2), .DEPTH(4), .INIT_VAL(4'h0)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    sysu_sram_sync #(.DATA_W(4), .ADDR_W(2), .DEPTH(3), .INIT_VAL(4'h0)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_a(input logic [1:0] a);
        if_a.rd = 1'b1; if_a.wr = 1'b0; if_a.addr = a;
        tick();
        if_a.rd = 1'b0;
    endtask

    task automatic wr_a(input logic [1:0] a, input logic [3:0] d, input logic inj);
        if_a.wr = 1'b1; if_a.rd = 1'b0; if_a.addr = a; if_a.din = d; if_a.perr_inj = inj;
        tick();
        if_a.wr = 1'b0; if_a.perr_inj = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        if_a.en = 1'b1; if_a.wr = 1'b0; if_a.rd = 1'b0; if_a.addr = '0; if_a.din = '0; if_a.perr_inj = 1'b0;
        if_b.en = 1'b0; if_b.wr = 1'b0; if_b.rd = 1'b0; if_b.addr = '0; if_b.din = '0; if_b.perr_inj = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // power-up init: read requested throughout busy must be dropped
        if_a.en = 1'b0; if_a.rd = 1'b1; if_a.addr = 2'd1;
        chk("reset_dout", if_a.dout, 4'h0);
        chk("reset_addr_err", {3'b0, if_a.addr_err}, 4'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("init_busy_a_%0d", i), {3'b0, if_a.busy}, 4'h1);
            chk($sformatf("init_busy_b_%0d", i), {3'b0, if_b.busy}, (i < 3) ? 4'h1 : 4'h0);
            chk($sformatf("init_nodv_%0d", i), {3'b0, if_a.dvalid}, 4'h0);
            tick();
        end
        if_a.rd = 1'b0;
        chk("init_done_busy", {3'b0, if_a.busy}, 4'h0);
        chk("init_last_nodv", {3'b0, if_a.dvalid}, 4'h0);

        // back-to-back reads of every word after init
        if_a.rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_a.addr = 2'(i);
            tick();
            chk($sformatf("init_rd_data_%0d", i), if_a.dout, 4'h0);
            chk($sformatf("init_rd_dv_%0d", i), {3'b0, if_a.dvalid}, 4'h1);
        end
        if_a.rd = 1'b0;
        tick();
        chk("b2b_dv_drop", {3'b0, if_a.dvalid}, 4'h0);

        // write then read, hold, tristate
        wr_a(2'd2, 4'hA, 1'b0);
        chk("wr_no_dv", {3'b0, if_a.dvalid}, 4'h0);
        rd_a(2'd2);
        chk("rd2_data", if_a.dout, 4'hA);
        chk("rd2_dv", {3'b0, if_a.dvalid}, 4'h1);
        chk("rd2_perr", {3'b0, if_a.perr}, 4'h0);
        tick();
        chk("rd2_hold", if_a.dout, 4'hA);
        chk("rd2_dv_pulse", {3'b0, if_a.dvalid}, 4'h0);
        if_a.en = 1'b1;
        #1;
        checks++;
        assert (if_a.dout === 4'bzzzz) else begin
            errors++;
            $error("FAIL dout_hiz observed=%h expected=zzzz", if_a.dout);
        end
        rd_a(2'd2);
        chk("en_hi_no_dv", {3'b0, if_a.dvalid}, 4'h0);
        if_a.en = 1'b0;
        #1;
        chk("en_lo_dout", if_a.dout, 4'hA);

        // write-first collision
        wr_a(2'd1, 4'h3, 1'b0);
        if_a.wr = 1'b1; if_a.rd = 1'b1; if_a.addr = 2'd1; if_a.din = 4'hC;
        tick();
        if_a.wr = 1'b0; if_a.rd = 1'b0;
        chk("coll_data", if_a.dout, 4'hC);
        chk("coll_dv", {3'b0, if_a.dvalid}, 4'h1);
        rd_a(2'd0);
        chk("coll_other", if_a.dout, 4'h0);
        rd_a(2'd1);
        chk("coll_later", if_a.dout, 4'hC);

        // out-of-range on the DEPTH=3 instance
        if_b.wr = 1'b1; if_b.addr = 2'd2; if_b.din = 4'h7;
        tick();
        chk("b_wr2_aerr", {3'b0, if_b.addr_err}, 4'h0);
        if_b.addr = 2'd3; if_b.din = 4'hF;
        tick();
        if_b.wr = 1'b0;
        chk("b_wr3_aerr", {3'b0, if_b.addr_err}, 4'h1);
        chk("b_wr3_nodv", {3'b0, if_b.dvalid}, 4'h0);
        tick();
        chk("b_aerr_pulse", {3'b0, if_b.addr_err}, 4'h0);
        if_b.rd = 1'b1;
        if_b.addr = 2'd0; tick(); chk("b_rd0", if_b.dout, 4'h0);
        if_b.addr = 2'd1; tick(); chk("b_rd1", if_b.dout, 4'h0);
        if_b.addr = 2'd2; tick(); chk("b_rd2", if_b.dout, 4'h7);
        chk("b_rd2_aerr", {3'b0, if_b.addr_err}, 4'h0);
        if_b.addr = 2'd3; tick();
        if_b.rd = 1'b0;
        chk("b_rd3_data", if_b.dout, 4'h0);
        chk("b_rd3_dv", {3'b0, if_b.dvalid}, 4'h1);
        chk("b_rd3_aerr", {3'b0, if_b.addr_err}, 4'h1);

        // reset in the middle of init after earlier writes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if_a.rd = 1'b1; if_a.addr = 2'd2;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rinit_busy_%0d", i), {3'b0, if_a.busy}, 4'h1);
            chk($sformatf("rinit_nodv_%0d", i), {3'b0, if_a.dvalid}, 4'h0);
            tick();
        end
        if_a.rd = 1'b0;
        chk("rinit_done", {3'b0, if_a.busy}, 4'h0);
        chk("rinit_last_nodv", {3'b0, if_a.dvalid}, 4'h0);
        for (int i = 0; i < 4; i++) begin
            rd_a(2'(i));
            chk($sformatf("rinit_rd_%0d", i), if_a.dout, 4'h0);
        end

        // parity injection
        wr_a(2'd0, 4'h5, 1'b1);
        rd_a(2'd0);
        chk("par_inj_data", if_a.dout, 4'h5);
        chk("par_inj_dv", {3'b0, if_a.dvalid}, 4'h1);
`ifdef SYSU_SRAM_PARITY_EN
        chk("par_inj_perr", {3'b0, if_a.perr}, 4'h1);
`else
        chk("par_off_perr", {3'b0, if_a.perr}, 4'h0);
`endif
        wr_a(2'd0, 4'h5, 1'b0);
        rd_a(2'd0);
        chk("par_ok_data", if_a.dout, 4'h5);
        chk("par_ok_perr", {3'b0, if_a.perr}, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
